// File: rtl/dram_bus_master.sv
// Block-transfer engine between the cache refill/writeback path and the DRAM bus.
// One block read or write at a time; word address steps per DRAM cycle, ends on acknowledge or timeout.
module dram_bus_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int CYCLE_TIME = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] req_wdata,
    output logic                             req_ready,
    output logic                             resp_valid,
    output logic                             resp_error,
    output logic [BLOCK_SIZE*WORD_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0]            address,
    inout  wire  [WORD_WIDTH-1:0]            data,
    output logic                             read_enable,
    output logic                             write_enable,
    input  logic                             read_data_enable,
    input  logic                             write_data_enable,
    input  logic                             acknowledge,
    output logic [2:0]                       state_dbg
);
    // Request handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both 1; req_ready is high only in IDLE and not on the first cycle out of reset.
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] READ_WAIT   = 3'd1;
    localparam logic [2:0] READ_BURST  = 3'd2;
    localparam logic [2:0] WRITE_WAIT  = 3'd3;
    localparam logic [2:0] WRITE_BURST = 3'd4;
    localparam logic [2:0] RELEASE     = 3'd5;
    localparam logic [2:0] DONE        = 3'd6;

    localparam int BW = BLOCK_SIZE * WORD_WIDTH;
    localparam int KW = $clog2(BLOCK_SIZE) + 1;
    localparam int CW = $clog2(CYCLE_TIME) + 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [BW-1:0]         wdata_q, wdata_d;
    logic [BW-1:0]         rdata_q, rdata_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic                  active;
    logic                  drive;
    logic [KW-1:0]         k_idx;
    logic                  last_cycle;

    // Once the last word is done, k sits at BLOCK_SIZE but address/data stay on the last word.
    always_comb begin
        k_idx      = (k_q >= KW'(BLOCK_SIZE)) ? KW'(BLOCK_SIZE - 1) : k_q;
        last_cycle = (cyc_q == CW'(CYCLE_TIME - 1));
        active     = (state_q == READ_WAIT) || (state_q == READ_BURST) ||
                     (state_q == WRITE_WAIT) || (state_q == WRITE_BURST);
        drive      = (state_q == WRITE_WAIT) || (state_q == WRITE_BURST);
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        k_d     = k_q;
        cyc_d   = cyc_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ready_q && req_valid) begin
                    base_d  = req_addr & ~LOW_MASK;
                    wdata_d = req_wdata;
                    k_d     = '0;
                    cyc_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    if (req_write) begin
                        state_d = WRITE_WAIT;
                    end else begin
                        state_d = READ_WAIT;
                        rdata_d = '0;
                    end
                end
            end
            READ_WAIT: begin
                if (read_data_enable) begin
                    state_d = READ_BURST;
                    cyc_d   = '0;
                end
            end
            WRITE_WAIT: begin
                if (write_data_enable) begin
                    state_d = WRITE_BURST;
                    cyc_d   = '0;
                end
            end
            READ_BURST, WRITE_BURST: begin
                if (k_q < KW'(BLOCK_SIZE)) begin
                    if (last_cycle) begin
                        if (state_q == READ_BURST) begin
                            rdata_d[int'(k_idx)*WORD_WIDTH +: WORD_WIDTH] = data;
                        end
                        k_d   = k_q + 1'b1;
                        cyc_d = '0;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            RELEASE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acknowledge outranks both a word transfer and the timeout in the same cycle.
        if (active) begin
            tmo_d = tmo_q + 1'b1;
            if (acknowledge) begin
                state_d = RELEASE;
                err_d   = (k_q < KW'(BLOCK_SIZE));
                k_d     = k_q;
                rdata_d = rdata_q;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = RELEASE;
                err_d   = 1'b1;
            end
        end
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            k_q     <= '0;
            cyc_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            k_q     <= k_d;
            cyc_q   <= cyc_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready    = ready_q;
    assign resp_valid   = (state_q == DONE);
    assign resp_error   = (state_q == DONE) && err_q;
    assign resp_rdata   = rdata_q;
    assign read_enable  = (state_q == READ_WAIT) || (state_q == READ_BURST);
    assign write_enable = drive;
    assign address      = active ? (base_q + ADDR_WIDTH'(k_idx)) : '0;
    assign data         = drive ? wdata_q[int'(k_idx)*WORD_WIDTH +: WORD_WIDTH] : 'z;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_dram_bus_master.sv
// Bench for dram_bus_master: behavioural DRAM with fixed access latency, scoreboarded
// responses, address and write-data streams, plus directed timeout/early-ack/reset cases.
module tb_dram_bus_master;
    localparam int AW  = 32;
    localparam int WW  = 32;
    localparam int BS  = 4;
    localparam int BW  = BS * WW;
    localparam int TO  = 20;
    localparam int LAT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [BW-1:0] req_wdata = '0;
    logic          req_ready, resp_valid, resp_error;
    logic [BW-1:0] resp_rdata;
    logic [AW-1:0] address;
    wire  [WW-1:0] data;
    logic          read_enable, write_enable;
    logic          read_data_enable, write_data_enable, acknowledge;
    logic [2:0]    state_dbg;

    // DRAM model state
    logic [WW-1:0] mem [0:1023];
    int            ph = 0;
    int            ack_mode = 0;  // 0 normal, 1 never, 2 after two words
    logic          noise_on = 1'b0;
    logic          n_rde = 1'b0, n_wde = 1'b0, n_ack = 1'b0;
    logic          poke_en = 1'b0;
    logic [9:0]    poke_addr = '0;
    logic [WW-1:0] poke_val = '0;
    logic          en;

    // Scoreboard: {check_rdata, error, rdata}
    logic [BW+1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [WW-1:0] exp_wd_q[$];
    int            checks = 0;
    int            errors = 0;
    int            resp_cnt = 0;
    int            en_run = 0;
    int            last_en = 0;
    logic          en_d1 = 1'b0, en_d2 = 1'b0;

    always #5 clock = ~clock;

    dram_bus_master #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS), .CYCLE_TIME(1), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .address(address), .data(data),
        .read_enable(read_enable), .write_enable(write_enable),
        .read_data_enable(read_data_enable), .write_data_enable(write_data_enable),
        .acknowledge(acknowledge), .state_dbg(state_dbg)
    );

    assign en = read_enable | write_enable;
    assign read_data_enable  = (read_enable && ph >= LAT && ph <= LAT + BS) | (noise_on & n_rde);
    assign write_data_enable = (write_enable && ph >= LAT && ph <= LAT + BS) | (noise_on & n_wde);
    assign acknowledge = (en && ((ack_mode == 0 && ph == LAT + 1 + BS) || (ack_mode == 2 && ph == LAT + 3)))
                         | (noise_on & n_ack);
    assign data = (read_enable && read_data_enable) ? mem[address[9:0]] : 'z;

    always @(posedge clock or negedge reset) begin
        if (!reset) ph <= 0;
        else if (en) ph <= ph + 1;
        else ph <= 0;
    end

    always @(posedge clock) begin
        if (poke_en) mem[poke_addr] <= poke_val;
        else if (reset && write_enable && ph >= LAT + 1 && ph <= LAT + BS) mem[address[9:0]] <= data;
    end

    task automatic check(input string tag, input logic [BW+1:0] obs, input logic [BW+1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: bus exclusivity, address/data streams, response scoreboard
    always @(negedge clock) begin
        logic [BW+1:0] e;
        if (reset) begin
            check("bus_excl", BW'(read_enable & write_enable), '0);
            if (en && ph >= LAT + 1 && ph <= LAT + BS && exp_addr_q.size() > 0)
                check("address", BW'(address), BW'(exp_addr_q.pop_front()));
            if (write_enable && ph >= LAT + 1 && ph <= LAT + BS && exp_wd_q.size() > 0)
                check("wdata_bus", BW'(data), BW'(exp_wd_q.pop_front()));
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_error", BW'(resp_error), BW'(e[BW]));
                    if (e[BW+1]) check("resp_rdata", BW'(resp_rdata), BW'(e[BW-1:0]));
                    check("release_gap", BW'({en_d2, en_d1}), BW'(2'b10));
                end
                resp_cnt++;
            end
        end
        if (en) en_run++;
        else if (en_run != 0) begin
            last_en = en_run;
            en_run = 0;
        end
        en_d2 = en_d1;
        en_d1 = en;
    end

    task automatic poke(input logic [AW-1:0] a, input logic [WW-1:0] v);
        poke_addr = a[9:0];
        poke_val  = v;
        poke_en   = 1'b1;
        @(posedge clock);
        #1 poke_en = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                         input logic [BW-1:0] exp_rd, input logic exp_err, input int mode);
        logic [AW-1:0] base;
        int nw;
        bit rdy;
        base = a & ~AW'(BS - 1);
        nw = (mode == 2) ? 2 : BS;
        ack_mode = mode;
        exp_q.push_back({(!wr && !exp_err), exp_err, exp_rd});
        for (int i = 0; i < nw; i++) begin
            exp_addr_q.push_back(base + AW'(i));
            if (wr) exp_wd_q.push_back(wd[i*WW +: WW]);
        end
        rdy = 0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clock);
            if (req_ready) rdy = 1;
        end
        check("ready_wait", BW'(rdy), BW'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int exp_en);
        int start;
        bit seen;
        start = resp_cnt;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (resp_cnt > start) seen = 1;
        end
        check("resp_seen", BW'(seen), BW'(1));
        check("enable_cycles", BW'(last_en), BW'(exp_en));
        check("addr_stream_left", BW'(exp_addr_q.size()), '0);
        @(posedge clock);
        #1 check("ready_return", BW'(req_ready), BW'(1));
    endtask

    initial begin
        logic [BW-1:0] blk_a, blk_d, blk_w, blk_r;
        logic [AW-1:0] ra;
        bit hit;
        for (int i = 0; i < BS; i++) begin
            blk_a[i*WW +: WW] = 32'hA0A0_0000 | 32'(i);
            blk_d[i*WW +: WW] = $urandom;
            blk_w[i*WW +: WW] = 32'hC0DE_0000 + 32'(i * 17);
        end

        // Reset held with noisy inputs
        noise_on = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            n_rde = 1'($urandom_range(0, 1));
            n_wde = 1'($urandom_range(0, 1));
            n_ack = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("rst_outs", BW'({req_ready, read_enable, write_enable, resp_valid, resp_error}), '0);
            check("rst_addr", BW'(address), '0);
            check("rst_rdata", BW'(resp_rdata), '0);
        end
        noise_on = 1'b0;
        req_valid = 1'b0;
        reset = 1'b1;
        #1 check("ready_before_edge", BW'(req_ready), '0);
        @(posedge clock);
        #1 check("ready_after_reset", BW'(req_ready), BW'(1));

        for (int i = 0; i < BS; i++) poke(32'h100 + 32'(i), blk_a[i*WW +: WW]);
        for (int i = 0; i < BS; i++) poke(32'h3FC + 32'(i), blk_w[i*WW +: WW]);

        // Block read, unaligned request address
        issue(1'b0, 32'h102, '0, blk_a, 1'b0, 0);
        wait_done(LAT + BS + 2);

        // Block write then read back
        issue(1'b1, 32'h200, blk_d, '0, 1'b0, 0);
        wait_done(LAT + BS + 2);
        issue(1'b0, 32'h203, '0, blk_d, 1'b0, 0);
        wait_done(LAT + BS + 2);

        // Top-of-address-space block
        issue(1'b0, 32'hFFFF_FFFE, '0, blk_w, 1'b0, 0);
        wait_done(LAT + BS + 2);

        // Random blocks
        for (int n = 0; n < 3; n++) begin
            ra = 32'($urandom_range(32'h90, 32'hBF)) * 4;
            for (int i = 0; i < BS; i++) begin
                blk_r[i*WW +: WW] = $urandom;
                poke(ra + 32'(i), blk_r[i*WW +: WW]);
            end
            issue(1'b0, ra | 32'($urandom_range(0, BS - 1)), '0, blk_r, 1'b0, 0);
            wait_done(LAT + BS + 2);
        end

        // Timeout: no acknowledge ever
        issue(1'b0, 32'h300, '0, '0, 1'b1, 1);
        wait_done(TO);

        // Early acknowledge after two words
        issue(1'b0, 32'h100, '0, '0, 1'b1, 2);
        wait_done(LAT + 4);

        // Reset mid-burst with k=2
        issue(1'b0, 32'h100, '0, blk_a, 1'b0, 0);
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(posedge clock);
            #1;
            if (ph == LAT + 3) hit = 1;
        end
        check("reach_mid_burst", BW'(hit), BW'(1));
        reset = 1'b0;
        #1;
        check("midrst_outs", BW'({req_ready, read_enable, write_enable, resp_valid}), '0);
        check("midrst_addr", BW'(address), '0);
        exp_q.delete();
        exp_addr_q.delete();
        exp_wd_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 check("ready_after_midrst", BW'(req_ready), BW'(1));
        issue(1'b0, 32'h201, '0, blk_d, 1'b0, 0);
        wait_done(LAT + BS + 2);
        check("scoreboard_empty", BW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
